// File: rtl/ps2_rx_frame_if.sv
// PS/2 receiver bus: raw keyboard lines in, received byte and status pulses out.
// master = line driver / byte consumer side, slave = the receiver.
interface ps2_rx_frame_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ps2dis_data;
    logic       ps2dis_recFlag;
    logic       frame_err;
    logic       busy;

    modport master (
        output ps2_clk, ps2_data,
        input  ps2dis_data, ps2dis_recFlag, frame_err, busy
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output ps2dis_data, ps2dis_recFlag, frame_err, busy
    );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronise + deglitch ps2_clk, shift 11-bit frames, validate, emit byte.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_frame #(
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic            clk,
    input  logic            rst,
    ps2_rx_frame_if.slave   bus
);

    localparam int STAB_W = $clog2(FILT_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILT_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t            state_q, state_d;
    logic [1:0]        clk_sync, data_sync;
    logic [STAB_W-1:0] stab_cnt;
    logic              filt_clk, filt_prev;
    logic [9:0]        shift_q;
    logic [3:0]        bit_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [7:0]        data_q;
    logic              rec_flag_q, err_q;

    logic data_s, fe;
    logic start_frame, shift_bit, abort, idle_err;
    logic frame_done, frame_ok, parity_ok;

    assign data_s = data_sync[1];
    assign fe     = filt_prev & ~filt_clk;

    // Synchronisers idle high so reset release never looks like a falling edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stab_cnt  <= '0;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            filt_prev <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                stab_cnt <= '0;
            end else if (stab_cnt == STAB_LAST) begin
                filt_clk <= clk_sync[1];
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // CHECK behaves like IDLE for a new edge so a start bit landing there is kept.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        shift_bit   = 1'b0;
        abort       = 1'b0;
        idle_err    = 1'b0;
        case (state_q)
            IDLE, CHECK: begin
                state_d = IDLE;
                if (fe) begin
                    if (!data_s) begin
                        start_frame = 1'b1;
                        state_d     = RECV;
                    end else begin
                        idle_err = 1'b1;
                    end
                end
            end
            RECV: begin
                if (fe) begin
                    shift_bit = 1'b1;
                    if (bit_cnt == 4'd10) state_d = CHECK;
                end else if (to_cnt == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // At the stop edge shift_q holds {parity, data[7:0], start}; the stop bit is data_s.
    assign frame_done = shift_bit && (bit_cnt == 4'd10);
`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^shift_q[9:1];
`else
    assign parity_ok = 1'b1;
`endif
    assign frame_ok = !shift_q[0] && data_s && parity_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (start_frame) begin
            shift_q <= {data_s, 9'b0};
            bit_cnt <= 4'd1;
            to_cnt  <= '0;
        end else if (shift_bit) begin
            shift_q <= {data_s, shift_q[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            to_cnt  <= '0;
        end else if (abort) begin
            shift_q <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (state_q == RECV) begin
            if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    // Result registered on the stop edge, so the pulses and new byte appear in the CHECK cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q     <= 8'h00;
            rec_flag_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rec_flag_q <= frame_done && frame_ok;
            err_q      <= (frame_done && !frame_ok) || idle_err || abort;
            if (frame_done && frame_ok) data_q <= shift_q[8:1];
        end
    end

    assign bus.ps2dis_data    = data_q;
    assign bus.ps2dis_recFlag = rec_flag_q;
    assign bus.frame_err      = err_q;
    assign bus.busy           = (state_q == RECV);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: scaled PS/2 bit timing, pulse monitor, per-scenario tasks.
module tb_ps2_rx_frame;

    localparam int FILT_LEN    = 4;
    localparam int TIMEOUT_CYC = 400;
    localparam int HP          = 20;               // PS/2 half bit period in clk cycles
    localparam int LAT         = 2 + FILT_LEN + 1; // raw stop drop -> recFlag sample
`ifdef PS2_PARITY_CHECK_EN
    localparam logic [7:0] AFTER_PAR = 8'h29;
`else
    localparam logic [7:0] AFTER_PAR = 8'h1C;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_rx_frame_if bus ();

    ps2_rx_frame #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int stop_cyc     = 0;
    int rec_cnt      = 0;
    int err_cnt      = 0;
    int rec_cyc      = -1;
    int overlap_cnt  = 0;
    logic [7:0] rec_log [4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ps2dis_recFlag) begin
            if (rec_cnt < 4) rec_log[rec_cnt] = bus.ps2dis_data;
            rec_cnt = rec_cnt + 1;
            rec_cyc = cyc;
        end
        if (bus.frame_err) err_cnt = err_cnt + 1;
        if (bus.ps2dis_recFlag && bus.frame_err) overlap_cnt = overlap_cnt + 1;
    end

    task automatic clear_mon();
        rec_cnt = 0;
        err_cnt = 0;
        rec_cyc = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par_flip,
                                               input logic stop);
        return {stop, ~(^d) ^ par_flip, d, 1'b0};
    endfunction

    // Device style: data changes while clock is high, receiver samples on the falling edge.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = f[i];
            idle(HP);
            bus.ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            idle(HP);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        idle(3);
        tests_run++;
        if ({bus.ps2dis_data, bus.ps2dis_recFlag, bus.frame_err, bus.busy} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 000",
                     {bus.ps2dis_data, bus.ps2dis_recFlag, bus.frame_err, bus.busy});
        end
        rst = 1'b1;
        idle(20);
        tests_run++;
        if (rec_cnt !== 0 || err_cnt !== 0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_quiet: rec=%0d err=%0d busy=%b required 0 0 0",
                     rec_cnt, err_cnt, bus.busy);
        end
    endtask

    task automatic test_valid_byte();
        clear_mon();
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11);
        idle(2 * HP);
        tests_run++;
        if (rec_cnt !== 1 || rec_log[0] !== 8'h1C) begin
            tests_failed++;
            $display("FAIL valid_1c: pulses=%0d data=%h required 1 1c", rec_cnt, rec_log[0]);
        end
        tests_run++;
        if (rec_cyc - stop_cyc !== LAT) begin
            tests_failed++;
            $display("FAIL valid_latency: got %0d required %0d", rec_cyc - stop_cyc, LAT);
        end
        tests_run++;
        if (err_cnt !== 0 || bus.busy !== 1'b0 || bus.ps2dis_data !== 8'h1C) begin
            tests_failed++;
            $display("FAIL valid_status: err=%0d busy=%b data=%h required 0 0 1c",
                     err_cnt, bus.busy, bus.ps2dis_data);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_bits(make_frame(8'hF0, 1'b0, 1'b1), 11);
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11);
        idle(2 * HP);
        tests_run++;
        if (rec_cnt !== 2 || err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL b2b_counts: rec=%0d err=%0d required 2 0", rec_cnt, err_cnt);
        end
        tests_run++;
        if (rec_log[0] !== 8'hF0 || rec_log[1] !== 8'h1C) begin
            tests_failed++;
            $display("FAIL b2b_data: got %h %h required f0 1c", rec_log[0], rec_log[1]);
        end
    endtask

    task automatic test_bad_parity();
        clear_mon();
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 11);
        idle(2 * HP);
        tests_run++;
        if (rec_cnt !== 1 || bus.ps2dis_data !== 8'h29) begin
            tests_failed++;
            $display("FAIL parity_pre_29: rec=%0d data=%h required 1 29", rec_cnt, bus.ps2dis_data);
        end
        clear_mon();
        send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11);
        idle(2 * HP);
        tests_run++;
`ifdef PS2_PARITY_CHECK_EN
        if (rec_cnt !== 0 || err_cnt !== 1 || bus.ps2dis_data !== AFTER_PAR) begin
`else
        if (rec_cnt !== 1 || err_cnt !== 0 || bus.ps2dis_data !== AFTER_PAR) begin
`endif
            tests_failed++;
            $display("FAIL bad_parity: rec=%0d err=%0d data=%h required data %h",
                     rec_cnt, err_cnt, bus.ps2dis_data, AFTER_PAR);
        end
    endtask

    task automatic test_stop_err();
        clear_mon();
        send_bits(make_frame(8'h55, 1'b0, 1'b0), 11);
        idle(2 * HP);
        tests_run++;
        if (err_cnt !== 1 || rec_cnt !== 0) begin
            tests_failed++;
            $display("FAIL stop0_pulses: err=%0d rec=%0d required 1 0", err_cnt, rec_cnt);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.ps2dis_data !== AFTER_PAR) begin
            tests_failed++;
            $display("FAIL stop0_hold: busy=%b data=%h required 0 %h",
                     bus.busy, bus.ps2dis_data, AFTER_PAR);
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 5);
        idle(HP);
        tests_run++;
        if (bus.busy !== 1'b1 || err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL timeout_midframe: busy=%b err=%0d required 1 0", bus.busy, err_cnt);
        end
        idle(TIMEOUT_CYC + 50);
        tests_run++;
        if (err_cnt !== 1 || rec_cnt !== 0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_abort: err=%0d rec=%0d busy=%b required 1 0 0",
                     err_cnt, rec_cnt, bus.busy);
        end
        clear_mon();
        send_bits(make_frame(8'h29, 1'b0, 1'b1), 11);
        idle(2 * HP);
        tests_run++;
        if (rec_cnt !== 1 || rec_log[0] !== 8'h29 || err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL timeout_recover: rec=%0d data=%h err=%0d required 1 29 0",
                     rec_cnt, rec_log[0], err_cnt);
        end
    endtask

    task automatic test_glitch();
        // Data held low so a captured glitch would look like a start bit.
        int widths [2];
        widths[0] = 2;
        widths[1] = FILT_LEN - 1;
        foreach (widths[k]) begin
            clear_mon();
            bus.ps2_data = 1'b0;
            idle(HP);
            bus.ps2_clk = 1'b0;
            idle(widths[k]);
            bus.ps2_clk = 1'b1;
            idle(HP);
            bus.ps2_data = 1'b1;
            tests_run++;
            if (bus.busy !== 1'b0 || err_cnt !== 0 || rec_cnt !== 0) begin
                tests_failed++;
                $display("FAIL glitch_w%0d: busy=%b err=%0d rec=%0d required 0 0 0",
                         widths[k], bus.busy, err_cnt, rec_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        send_bits(make_frame(8'h3A, 1'b0, 1'b1), 6);
        idle(HP);
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_busy_before: got %b required 1", bus.busy);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.ps2dis_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_mid_async: busy=%b data=%h required 0 00", bus.busy, bus.ps2dis_data);
        end
        idle(3);
        rst = 1'b1;
        idle(TIMEOUT_CYC + 20);
        tests_run++;
        if (rec_cnt !== 0 || err_cnt !== 0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_quiet: rec=%0d err=%0d busy=%b required 0 0 0",
                     rec_cnt, err_cnt, bus.busy);
        end
        send_bits(make_frame(8'h1C, 1'b0, 1'b1), 11);
        idle(2 * HP);
        tests_run++;
        if (rec_cnt !== 1 || rec_log[0] !== 8'h1C || err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL rst_mid_recover: rec=%0d data=%h err=%0d required 1 1c 0",
                     rec_cnt, rec_log[0], err_cnt);
        end
    endtask

    task automatic test_pulse_exclusive();
        tests_run++;
        if (overlap_cnt !== 0) begin
            tests_failed++;
            $display("FAIL pulse_overlap: got %0d cycles required 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_valid_byte();
        test_back_to_back();
        test_bad_parity();
        test_stop_err();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        test_pulse_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
